m3uart_cmd_rx: RTL and testbench



---
 rtl/m3uart_cmd_rx_if.sv | 25 ++
 rtl/m3uart_cmd_rx.sv | 141 ++++++++++++++
 tb/tb_m3uart_cmd_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/m3uart_cmd_rx_if.sv
// rtl/m3uart_cmd_rx_if.sv - serial pad input and decoded command outputs of the UART command receiver
interface m3uart_cmd_rx_if;
    logic       uRx;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       frameErr;
    logic       cmdErr;
    logic       m3start;
    logic       m3forceStop;
    logic       m3invRotate;
    logic       m3freqINC;
    logic       m3freqDEC;

    modport master (
        output uRx,
        input  rxByte, rxValid, frameErr, cmdErr,
        input  m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC
    );

    modport slave (
        input  uRx,
        output rxByte, rxValid, frameErr, cmdErr,
        output m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC
    );
endinterface

// File: rtl/m3uart_cmd_rx.sv
// rtl/m3uart_cmd_rx.sv - 8N1 UART receiver decoding single-character motor commands
module m3uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = 217
) (
    input  logic            clk50mhz,
    input  logic            reset,
    m3uart_cmd_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRKWAIT
    } state_t;

    localparam logic [8:0] CNT_BIT_LAST  = 9'(CLKS_PER_BIT - 1);
    localparam logic [8:0] CNT_HALF_LAST = 9'(HALF_BIT - 1);

    state_t     r_state;
    logic       r_rx_meta;
    logic       r_rx_s;
    logic [8:0] r_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_rx_byte;
    logic       r_rx_valid;
    logic       r_frame_err;
    logic       r_cmd_err;
    logic       r_start;
    logic       r_force_stop;
    logic       r_inv_rotate;
    logic       r_freq_inc;
    logic       r_freq_dec;

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rx_byte    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_start      <= 1'b0;
            r_force_stop <= 1'b0;
            r_inv_rotate <= 1'b0;
            r_freq_inc   <= 1'b0;
            r_freq_dec   <= 1'b0;
        end else begin
            r_rx_meta   <= bus.uRx;
            r_rx_s      <= r_rx_meta;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_freq_inc  <= 1'b0;
            r_freq_dec  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        // The detect cycle is already cycle 0 of the start bit.
                        r_state <= S_START;
                        r_cnt   <= 9'd1;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_rx_byte  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_state    <= S_IDLE;
                            case (r_shift)
                                8'h53: if (!r_force_stop) r_start <= 1'b1;
                                8'h50: r_start <= 1'b0;
                                8'h58: begin
                                    r_force_stop <= 1'b1;
                                    r_start      <= 1'b0;
                                end
                                8'h43: r_force_stop <= 1'b0;
                                8'h52: r_inv_rotate <= ~r_inv_rotate;
                                8'h2B: r_freq_inc   <= 1'b1;
                                8'h2D: r_freq_dec   <= 1'b1;
                                default: r_cmd_err  <= 1'b1;
                            endcase
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BRKWAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                S_BRKWAIT: begin
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rxByte      = r_rx_byte;
    assign bus.rxValid     = r_rx_valid;
    assign bus.frameErr    = r_frame_err;
    assign bus.cmdErr      = r_cmd_err;
    assign bus.m3start     = r_start;
    assign bus.m3forceStop = r_force_stop;
    assign bus.m3invRotate = r_inv_rotate;
    assign bus.m3freqINC   = r_freq_inc;
    assign bus.m3freqDEC   = r_freq_dec;

endmodule

// File: tb/tb_m3uart_cmd_rx.sv
// tb/tb_m3uart_cmd_rx.sv - directed table-driven bench for the UART command receiver
module tb_m3uart_cmd_rx;
    localparam int CPB = 434;

    logic clk50mhz = 1'b0;
    logic reset;
    int   cyc = 0;

    m3uart_cmd_rx_if bus ();

    m3uart_cmd_rx #(.CLKS_PER_BIT(434), .HALF_BIT(217)) dut (
        .clk50mhz (clk50mhz),
        .reset    (reset),
        .bus      (bus)
    );

    always #10 clk50mhz = ~clk50mhz;
    always @(posedge clk50mhz) cyc <= cyc + 1;

    int   n_valid = 0, n_ferr = 0, n_cerr = 0, n_inc = 0, n_dec = 0;
    int   n_wide = 0, n_overlap = 0, valid_cyc = 0;
    logic start_at_valid = 1'b0, start_before_valid = 1'b0, prev_start = 1'b0;
    logic p_valid = 1'b0, p_ferr = 1'b0, p_cerr = 1'b0, p_inc = 1'b0, p_dec = 1'b0;

    always @(negedge clk50mhz) begin
        if (bus.rxValid === 1'b1) begin
            n_valid            <= n_valid + 1;
            valid_cyc          <= cyc;
            start_at_valid     <= bus.m3start;
            start_before_valid <= prev_start;
        end
        if (bus.frameErr === 1'b1)  n_ferr <= n_ferr + 1;
        if (bus.cmdErr === 1'b1)    n_cerr <= n_cerr + 1;
        if (bus.m3freqINC === 1'b1) n_inc  <= n_inc + 1;
        if (bus.m3freqDEC === 1'b1) n_dec  <= n_dec + 1;
        if ((bus.rxValid === 1'b1 && p_valid) || (bus.frameErr === 1'b1 && p_ferr) ||
            (bus.cmdErr === 1'b1 && p_cerr) || (bus.m3freqINC === 1'b1 && p_inc) ||
            (bus.m3freqDEC === 1'b1 && p_dec))
            n_wide <= n_wide + 1;
        if ((bus.frameErr === 1'b1 && (bus.rxValid || bus.cmdErr || bus.m3freqINC || bus.m3freqDEC)) ||
            ((bus.cmdErr === 1'b1 || bus.m3freqINC === 1'b1 || bus.m3freqDEC === 1'b1) && bus.rxValid !== 1'b1) ||
            ((bus.cmdErr + bus.m3freqINC + bus.m3freqDEC) > 2'd1))
            n_overlap <= n_overlap + 1;
        prev_start <= bus.m3start;
        p_valid    <= (bus.rxValid === 1'b1);
        p_ferr     <= (bus.frameErr === 1'b1);
        p_cerr     <= (bus.cmdErr === 1'b1);
        p_inc      <= (bus.m3freqINC === 1'b1);
        p_dec      <= (bus.m3freqDEC === 1'b1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk50mhz);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopv, input int stop_len, output int t_drive);
        tick(1);
        bus.uRx = 1'b0;
        t_drive = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.uRx = d[i];
            tick(CPB);
        end
        bus.uRx = stopv;
        tick(stop_len);
        bus.uRx = 1'b1;
        tick(100);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       e_start;
        logic       e_stop;
        logic       e_inv;
        int         e_inc;
        int         e_dec;
        int         e_cerr;
    } vec_t;

    vec_t vecs[9];
    int   t0, s_valid, s_ferr, s_cerr, s_inc, s_dec;

    task automatic snap();
        s_valid = n_valid; s_ferr = n_ferr; s_cerr = n_cerr; s_inc = n_inc; s_dec = n_dec;
    endtask

    initial begin
        vecs[0] = '{8'h58, 1'b0, 1'b1, 1'b0, 0, 0, 0};
        vecs[1] = '{8'h53, 1'b0, 1'b1, 1'b0, 0, 0, 0};
        vecs[2] = '{8'h43, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        vecs[3] = '{8'h53, 1'b1, 1'b0, 1'b0, 0, 0, 0};
        vecs[4] = '{8'h2B, 1'b1, 1'b0, 1'b0, 1, 0, 0};
        vecs[5] = '{8'h2D, 1'b1, 1'b0, 1'b0, 0, 1, 0};
        vecs[6] = '{8'h52, 1'b1, 1'b0, 1'b1, 0, 0, 0};
        vecs[7] = '{8'h52, 1'b1, 1'b0, 1'b0, 0, 0, 0};
        vecs[8] = '{8'h41, 1'b1, 1'b0, 1'b0, 0, 0, 1};

        bus.uRx = 1'b1;
        reset   = 1'b1;
        tick(3);
        reset = 1'b0;
        check("reset_rxByte", int'(bus.rxByte), 0);
        check("reset_pulses", int'({bus.rxValid, bus.frameErr, bus.cmdErr, bus.m3freqINC, bus.m3freqDEC}), 0);
        check("reset_levels", int'({bus.m3start, bus.m3forceStop, bus.m3invRotate}), 0);
        snap();
        tick(10000);
        check("idle_no_pulses", (n_valid - s_valid) + (n_ferr - s_ferr) + (n_cerr - s_cerr) + (n_inc - s_inc) + (n_dec - s_dec), 0);

        snap();
        send_frame(8'h53, 1'b1, CPB, t0);
        check("s_valid_count", n_valid - s_valid, 1);
        check("s_latency", valid_cyc - t0, 4125);
        check("s_rxByte", int'(bus.rxByte), 8'h53);
        check("s_start_with_valid", int'(start_at_valid), 1);
        check("s_start_before_valid", int'(start_before_valid), 0);

        snap();
        tick(1);
        bus.uRx = 1'b0;
        tick(100);
        bus.uRx = 1'b1;
        tick(1000);
        check("glitch_no_pulses", (n_valid - s_valid) + (n_ferr - s_ferr) + (n_cerr - s_cerr), 0);

        snap();
        send_frame(8'h55, 1'b0, 2000, t0);
        check("ferr_count", n_ferr - s_ferr, 1);
        check("ferr_no_valid", n_valid - s_valid, 0);
        check("ferr_no_cmderr", n_cerr - s_cerr, 0);
        check("ferr_rxByte_kept", int'(bus.rxByte), 8'h53);
        check("ferr_start_kept", int'(bus.m3start), 1);

        snap();
        send_frame(8'h50, 1'b1, CPB, t0);
        check("p_valid_count", n_valid - s_valid, 1);
        check("p_rxByte", int'(bus.rxByte), 8'h50);
        check("p_start_cleared", int'(bus.m3start), 0);

        for (int v = 0; v < 9; v++) begin
            snap();
            send_frame(vecs[v].data, 1'b1, CPB, t0);
            check($sformatf("vec%0d_rxByte", v), int'(bus.rxByte), int'(vecs[v].data));
            check($sformatf("vec%0d_start", v), int'(bus.m3start), int'(vecs[v].e_start));
            check($sformatf("vec%0d_forceStop", v), int'(bus.m3forceStop), int'(vecs[v].e_stop));
            check($sformatf("vec%0d_invRotate", v), int'(bus.m3invRotate), int'(vecs[v].e_inv));
            check($sformatf("vec%0d_valid", v), n_valid - s_valid, 1);
            check($sformatf("vec%0d_freqINC", v), n_inc - s_inc, vecs[v].e_inc);
            check($sformatf("vec%0d_freqDEC", v), n_dec - s_dec, vecs[v].e_dec);
            check($sformatf("vec%0d_cmdErr", v), n_cerr - s_cerr, vecs[v].e_cerr);
            check($sformatf("vec%0d_frameErr", v), n_ferr - s_ferr, 0);
            check($sformatf("vec%0d_latency", v), valid_cyc - t0, 4125);
        end

        snap();
        tick(1);
        bus.uRx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.uRx = vecs[3].data[i];
            tick(CPB);
        end
        bus.uRx = vecs[3].data[4];
        tick(200);
        reset = 1'b1;
        tick(1);
        reset   = 1'b0;
        bus.uRx = 1'b1;
        tick(1000);
        check("midrst_no_valid", n_valid - s_valid, 0);
        check("midrst_no_errs", (n_ferr - s_ferr) + (n_cerr - s_cerr), 0);
        check("midrst_start", int'(bus.m3start), 0);
        check("midrst_rxByte", int'(bus.rxByte), 0);

        snap();
        send_frame(8'h53, 1'b1, CPB, t0);
        check("post_rst_valid", n_valid - s_valid, 1);
        check("post_rst_start", int'(bus.m3start), 1);
        check("post_rst_rxByte", int'(bus.rxByte), 8'h53);
        check("post_rst_latency", valid_cyc - t0, 4125);

        check("pulse_width", n_wide, 0);
        check("pulse_overlap", n_overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
